// File: rtl/rc_req_gen_if.sv
// Bundle of flit header, allocator handshake, stage-2 result and
// statistics signals around one router request generator.
// master: the upstream/allocator side; slave: rc_req_gen itself.
interface rc_req_gen_if;
    logic        in_valid;
    logic [2:0]  in_dst_x;
    logic [2:0]  in_dst_y;
    logic [3:0]  in_dcnt;
    logic        in_ready;
    logic        stall;
    logic [3:0]  req;
    logic        req_valid;
    logic [4:0]  alloc;
    logic        out_valid;
    logic [4:0]  out_port;
    logic [3:0]  out_dcnt;
    logic        out_defl;
    logic        stat_clr;
    logic [15:0] defl_total;
    logic        err_noport;

    modport master (
        output in_valid, in_dst_x, in_dst_y, in_dcnt, stall, alloc, stat_clr,
        input  in_ready, req, req_valid, out_valid, out_port, out_dcnt,
               out_defl, defl_total, err_noport
    );

    modport slave (
        input  in_valid, in_dst_x, in_dst_y, in_dcnt, stall, alloc, stat_clr,
        output in_ready, req, req_valid, out_valid, out_port, out_dcnt,
               out_defl, defl_total, err_noport
    );
endinterface

// File: rtl/rc_req_gen.sv
// Two-stage route computation for a deflection router.
// Stage 1 turns the header destination into a productive-port request;
// stage 2 latches the port the allocator granted, flags deflections,
// bumps the deflection count and keeps deflection/no-port statistics.
// Port bit order: 0 N, 1 E, 2 S, 3 W, 4 Local.
module rc_req_gen #(
    parameter logic [2:0] LOCAL_X = 3'd0,
    parameter logic [2:0] LOCAL_Y = 3'd0
) (
    input logic         clk,
    input logic         rst_n,
    rc_req_gen_if.slave bus
);

    localparam int unsigned WIDTH_PV = 4;
    localparam int unsigned NUM_PORT = 5;
    localparam logic [NUM_PORT-1:0] EJECT_PORT = 5'b10000;
    localparam logic [3:0]          DCNT_MAX   = 4'hF;
    localparam logic [15:0]         TOTAL_MAX  = 16'hFFFF;

    // Stage-1 state
    logic [WIDTH_PV-1:0] req_q;
    logic                req_valid_q;
    logic                eject_q;
    logic [3:0]          dcnt_q;

    // Stage-2 state
    logic                out_valid_q;
    logic [NUM_PORT-1:0] out_port_q;
    logic [3:0]          out_dcnt_q;
    logic                out_defl_q;

    // Statistics
    logic [15:0]         defl_total_q;
    logic                err_noport_q;

    // Combinational results
    logic [WIDTH_PV-1:0] route_req;
    logic                route_eject;
    logic [NUM_PORT-1:0] grant;
    logic [3:0]          dcnt_inc;
    logic                nxt_valid;
    logic [NUM_PORT-1:0] nxt_port;
    logic [3:0]          nxt_dcnt;
    logic                nxt_defl;
    logic                nxt_drop;

    // Dimension comparison of the destination against this router.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // can leave it unassigned and infer a latch.
        route_req   = '0;
        route_eject = 1'b0;
        if (bus.in_dst_y > LOCAL_Y) route_req[0] = 1'b1;  // N
        if (bus.in_dst_x > LOCAL_X) route_req[1] = 1'b1;  // E
        if (bus.in_dst_y < LOCAL_Y) route_req[2] = 1'b1;  // S
        if (bus.in_dst_x < LOCAL_X) route_req[3] = 1'b1;  // W
        if (bus.in_dst_x == LOCAL_X && bus.in_dst_y == LOCAL_Y) route_eject = 1'b1;
    end

    // Stage 1: capture request, eject flag and count of an accepted header.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            req_q       <= '0;
            req_valid_q <= 1'b0;
            eject_q     <= 1'b0;
            dcnt_q      <= '0;
        end else if (!bus.stall) begin
            req_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                req_q   <= route_req;
                eject_q <= route_eject;
                dcnt_q  <= bus.in_dcnt;
            end else begin
                req_q   <= '0;
                eject_q <= 1'b0;
            end
        end
    end

    // Multi-hot grants collapse to their highest set bit.
    always_comb begin
        grant = '0;
        for (int i = 0; i < NUM_PORT; i++) begin
            if (bus.alloc[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
            end
        end
    end

    assign dcnt_inc = (dcnt_q == DCNT_MAX) ? DCNT_MAX : dcnt_q + 4'd1;

    // Stage-2 next values: eject, drop on missing grant, or productive/deflected.
    always_comb begin
        nxt_valid = 1'b0;
        nxt_port  = '0;
        nxt_dcnt  = '0;
        nxt_defl  = 1'b0;
        nxt_drop  = 1'b0;
        if (req_valid_q) begin
            if (eject_q) begin
                nxt_valid = 1'b1;
                nxt_port  = EJECT_PORT;
                nxt_dcnt  = dcnt_q;
            end else if (grant == '0) begin
                nxt_drop  = 1'b1;
            end else begin
                nxt_valid = 1'b1;
                nxt_port  = grant;
                nxt_defl  = ((grant & {1'b0, req_q}) == '0);
                nxt_dcnt  = nxt_defl ? dcnt_inc : dcnt_q;
            end
        end
    end

    // Stage 2: register the routed flit on every non-stalled edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_port_q  <= '0;
            out_dcnt_q  <= '0;
            out_defl_q  <= 1'b0;
        end else if (!bus.stall) begin
            out_valid_q <= nxt_valid;
            out_port_q  <= nxt_port;
            out_dcnt_q  <= nxt_dcnt;
            out_defl_q  <= nxt_defl;
        end
    end

    // Saturating deflection counter, counted as each deflected flit is
    // registered; a clear wins over a same-edge increment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            defl_total_q <= '0;
        end else if (bus.stat_clr) begin
            defl_total_q <= '0;
        end else if (!bus.stall && nxt_defl && defl_total_q != TOTAL_MAX) begin
            defl_total_q <= defl_total_q + 16'd1;
        end
    end

    // Sticky flag for a live non-eject flit that received no grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_noport_q <= 1'b0;
        end else if (!bus.stall && nxt_drop) begin
            err_noport_q <= 1'b1;
        end
    end

    assign bus.in_ready   = ~bus.stall;
    assign bus.req        = req_q;
    assign bus.req_valid  = req_valid_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_port   = out_port_q;
    assign bus.out_dcnt   = out_dcnt_q;
    assign bus.out_defl   = out_defl_q;
    assign bus.defl_total = defl_total_q;
    assign bus.err_noport = err_noport_q;

endmodule

// File: tb/tb_rc_req_gen.sv
// Self-checking bench for rc_req_gen at LOCAL=(2,2): directed scenarios
// plus randomized traffic, compared against a transaction-level model.
module tb_rc_req_gen;

    localparam int LX = 2;
    localparam int LY = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_err    = 0;

    rc_req_gen_if bus ();

    rc_req_gen #(.LOCAL_X(3'(LX)), .LOCAL_Y(3'(LY))) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: the flit waiting for a grant and the last routed flit.
    bit        m_rv, m_ej;
    bit [3:0]  m_req, m_d;
    bit        m_ov, m_defl, m_err;
    bit [4:0]  m_port;
    bit [3:0]  m_od;
    int        m_total;

    // Productive directions from signed coordinate differences.
    function automatic bit [3:0] route(input int x, input int y);
        int dx = x - LX;
        int dy = y - LY;
        return {dx < 0, dy < 0, dx > 0, dy > 0};
    endfunction

    function automatic bit [4:0] top_bit(input logic [4:0] a);
        for (int i = 4; i >= 0; i--)
            if (a[i]) return 5'(1 << i);
        return 5'b0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input int x, input int y, input int d,
                         input logic [4:0] a, input bit st, input bit clr);
        bus.in_valid = v;
        bus.in_dst_x = 3'(x);
        bus.in_dst_y = 3'(y);
        bus.in_dcnt  = 4'(d);
        bus.alloc    = a;
        bus.stall    = st;
        bus.stat_clr = clr;
    endtask

    task automatic model_edge();
        bit [4:0] g;
        bit       defl_now;
        defl_now = 1'b0;
        if (!rst_n) begin
            m_rv = 0; m_ej = 0; m_req = 0; m_d = 0;
            m_ov = 0; m_defl = 0; m_port = 0; m_od = 0;
            m_total = 0; m_err = 0;
            return;
        end
        if (!bus.stall) begin
            g = top_bit(bus.alloc);
            m_ov = 0; m_port = 0; m_od = 0; m_defl = 0;
            if (m_rv) begin
                if (m_ej) begin
                    m_ov = 1; m_port = 5'b10000; m_od = m_d;
                end else if (g == 0) begin
                    m_err = 1;
                end else begin
                    defl_now = ((g & {1'b0, m_req}) == 0);
                    m_ov = 1; m_port = g; m_defl = defl_now;
                    m_od = defl_now ? 4'((int'(m_d) + 1 > 15) ? 15 : int'(m_d) + 1) : m_d;
                end
            end
            m_rv = bus.in_valid;
            if (bus.in_valid) begin
                m_req = route(int'(bus.in_dst_x), int'(bus.in_dst_y));
                m_ej  = (int'(bus.in_dst_x) == LX) && (int'(bus.in_dst_y) == LY);
                m_d   = bus.in_dcnt;
            end else begin
                m_req = 0; m_ej = 0;
            end
        end
        if (bus.stat_clr) m_total = 0;
        else if (defl_now && m_total < 65535) m_total++;
    endtask

    task automatic compare_all();
        check("in_ready",   32'(bus.in_ready),   32'(!bus.stall));
        check("req_valid",  32'(bus.req_valid),  32'(m_rv));
        check("req",        32'(bus.req),        32'(m_req));
        check("out_valid",  32'(bus.out_valid),  32'(m_ov));
        check("out_defl",   32'(bus.out_defl),   32'(m_defl));
        if (m_ov) begin
            check("out_port", 32'(bus.out_port), 32'(m_port));
            check("out_dcnt", 32'(bus.out_dcnt), 32'(m_od));
        end
        check("defl_total", 32'(bus.defl_total), 32'(m_total));
        check("err_noport", 32'(bus.err_noport), 32'(m_err));
    endtask

    // One clock: inputs already driven; model and compare after the edge.
    task automatic step(input bit cmp);
        @(posedge clk);
        model_edge();
        #1;
        if (cmp) compare_all();
        @(negedge clk);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_req"},        32'(bus.req),        32'h0);
        check({tag, "_req_valid"},  32'(bus.req_valid),  32'h0);
        check({tag, "_out_valid"},  32'(bus.out_valid),  32'h0);
        check({tag, "_out_port"},   32'(bus.out_port),   32'h0);
        check({tag, "_out_dcnt"},   32'(bus.out_dcnt),   32'h0);
        check({tag, "_out_defl"},   32'(bus.out_defl),   32'h0);
        check({tag, "_defl_total"}, 32'(bus.defl_total), 32'h0);
        check({tag, "_err_noport"}, 32'(bus.err_noport), 32'h0);
    endtask

    initial begin
        logic [4:0] a;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 5'b0, 0, 0);
        @(negedge clk);

        // Reset state
        step(1);
        step(1);
        check_cleared("reset");

        // Productive grant, then deflecting grant for the same header
        rst_n = 1'b1;
        drive(1, 4, 1, 3, 5'b0, 0, 0);
        step(1);
        check("req_0110", 32'(bus.req), 32'h6);
        drive(1, 4, 1, 3, 5'b00010, 0, 0);
        step(1);
        check("prod_port", 32'(bus.out_port), 32'h02);
        check("prod_defl", 32'(bus.out_defl), 32'h0);
        check("prod_dcnt", 32'(bus.out_dcnt), 32'h3);
        drive(0, 0, 0, 0, 5'b01000, 0, 0);
        step(1);
        check("defl_flag",  32'(bus.out_defl),   32'h1);
        check("defl_dcnt",  32'(bus.out_dcnt),   32'h4);
        check("defl_total", 32'(bus.defl_total), 32'h1);

        // Eject flits ignore alloc, including an empty or multi-hot one
        for (int i = 0; i < 4; i++) begin
            a = (i == 0) ? 5'b00000 : (i == 1) ? 5'b00001 : (i == 2) ? 5'b01100 : 5'b11111;
            drive(1, LX, LY, i, a, 0, 0);
            step(1);
        end
        drive(0, 0, 0, 0, 5'b00100, 0, 0);
        step(1);
        check("eject_port", 32'(bus.out_port),   32'h10);
        check("eject_defl", 32'(bus.out_defl),   32'h0);
        check("eject_err",  32'(bus.err_noport), 32'h0);

        // Saturating hop count on a deflected flit
        drive(1, 0, 2, 15, 5'b0, 0, 0);
        step(1);
        drive(0, 0, 0, 0, 5'b00010, 0, 0);
        step(1);
        check("dcnt_sat", 32'(bus.out_dcnt), 32'hF);

        // Stall for 3 cycles with a flit waiting for its grant
        drive(1, 4, 1, 5, 5'b0, 0, 0);
        step(1);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 5'b01000, 1, 0);
            step(1);
            check("stall_req", 32'(bus.req), 32'h6);
        end
        drive(0, 0, 0, 0, 5'b00010, 0, 0);
        step(1);
        check("stall_out_valid", 32'(bus.out_valid), 32'h1);
        check("stall_out_port",  32'(bus.out_port),  32'h02);
        check("stall_out_dcnt",  32'(bus.out_dcnt),  32'h5);

        // Randomized traffic (every live non-eject flit gets some grant)
        for (int i = 0; i < 400; i++) begin
            a = 5'($urandom_range(1, 31));
            if (m_req != 0 && $urandom_range(0, 2) == 0) a = {1'b0, m_req & (~m_req + 4'd1)};
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 15), a, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 29) == 0);
            step(1);
        end

        // Counter saturation: 65535 deflections, then one more
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 5'b0, 0, 0);
        step(1);
        rst_n = 1'b1;
        drive(1, 4, 1, 15, 5'b01000, 0, 0);
        for (int i = 0; i < 65536; i++) step(0);
        compare_all();
        check("total_ffff", 32'(bus.defl_total), 32'hFFFF);
        check("dcnt_15",    32'(bus.out_dcnt),   32'hF);
        step(1);
        check("total_hold", 32'(bus.defl_total), 32'hFFFF);
        drive(1, 4, 1, 15, 5'b01000, 0, 1);
        step(1);
        check("clr_wins", 32'(bus.defl_total), 32'h0);

        // Missing grant drops the flit and latches the error
        drive(1, 4, 1, 1, 5'b0, 0, 0);
        step(1);
        drive(1, 0, 0, 2, 5'b00000, 0, 0);
        step(1);
        check("drop_valid", 32'(bus.out_valid),  32'h0);
        check("drop_err",   32'(bus.err_noport), 32'h1);
        for (int i = 0; i < 3; i++) begin
            drive(1, 5, 5, i, 5'b00001, 0, 0);
            step(1);
        end
        check("err_sticky", 32'(bus.err_noport), 32'h1);

        // Reset mid-stream dominates stall and stat_clr
        rst_n = 1'b0;
        drive(1, 5, 5, 7, 5'b00001, 1, 1);
        step(1);
        check_cleared("midreset");

        // First flit accepted on the first edge out of reset
        rst_n = 1'b1;
        drive(1, 1, 3, 9, 5'b00001, 0, 0);
        step(1);
        check("first_req_valid", 32'(bus.req_valid), 32'h1);
        check("first_req",       32'(bus.req),       32'h9);
        drive(0, 0, 0, 0, 5'b00001, 0, 0);
        step(1);
        step(1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
